// File: rtl/scan_mux_pkg.sv
// Shared types and channel-search helpers for the scanning multiplexer.
package scan_mux_pkg;

    localparam int unsigned MAX_CH = 64;
    localparam int unsigned MAX_SW = 6;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Result of a next-channel search: index found and whether the search wrapped past the top.
    typedef struct packed {
        logic              wrap;
        logic [MAX_SW-1:0] idx;
    } next_t;

    // Lowest set bit at or after idx, wrapping around n_ch; returns 0 if the mask is empty.
    function automatic logic [MAX_SW-1:0] first_at_or_after(
        input logic [MAX_CH-1:0] mask,
        input logic [MAX_SW-1:0] idx,
        input int unsigned       n_ch
    );
        logic [MAX_SW-1:0] r;
        logic              done;
        int unsigned       j;
        r    = '0;
        done = 1'b0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            j = (32'(idx) + k) % n_ch;
            if (k < n_ch && !done && mask[j[MAX_SW-1:0]]) begin
                done = 1'b1;
                r    = j[MAX_SW-1:0];
            end
        end
        return r;
    endfunction

    // Next set bit strictly after idx; wrap is set when the result is not above idx.
    function automatic next_t next_enabled(
        input logic [MAX_CH-1:0] mask,
        input logic [MAX_SW-1:0] idx,
        input int unsigned       n_ch
    );
        next_t             r;
        logic [MAX_SW-1:0] start;
        start  = MAX_SW'((32'(idx) + 32'd1) % n_ch);
        r.idx  = first_at_or_after(mask, start, n_ch);
        r.wrap = (r.idx <= idx);
        return r;
    endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Purely combinational N-to-1 indexed select over packed channel data.
module mux_n_to_1 #(
    parameter  int unsigned N_CH = 16,
    parameter  int unsigned W    = 1,
    localparam int unsigned SW   = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] w,
    input  logic [SW-1:0]     sel,
    output logic [W-1:0]      y_c
);

    // Channel k occupies w[k*W +: W].
    assign y_c = w[sel*W +: W];

endmodule

// File: rtl/scan_mux_n.sv
// N-channel registered multiplexer with manual select and an automatic dwell-based channel scanner.
module scan_mux_n
    import scan_mux_pkg::*;
#(
    parameter  int unsigned N_CH  = 16,
    parameter  int unsigned W     = 1,
    parameter  int unsigned DWELL = 1,
    localparam int unsigned SW    = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_CH*W-1:0] w,
    input  logic [SW-1:0]     s,
    input  logic              mode,
    input  logic [N_CH-1:0]   en_mask,
    output logic [W-1:0]      f,
    output logic [SW-1:0]     ch,
    output logic              valid,
    output logic              frame_done
);

    localparam int unsigned    CW       = 8;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);

    // Registered scan state
    logic [SW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic          wrap_q;
    logic          empty_q;
    mode_e         mode_q;

    // Next-state values
    logic [W-1:0]  f_n;
    logic [SW-1:0] ch_n;
    logic          valid_n;
    logic          fd_n;
    logic [SW-1:0] ptr_n;
    logic [CW-1:0] cnt_n;
    logic          wrap_n;
    logic          empty_n;
    mode_e         mode_n;

    // Combinational scan helpers
    logic          entry;
    logic          fresh;
    logic [SW-1:0] cur;
    logic [CW-1:0] cnt_eff;
    next_t         adv;
    logic [SW-1:0] sel;
    logic [W-1:0]  y_c;

    mux_n_to_1 #(
        .N_CH (N_CH),
        .W    (W)
    ) u_mux (
        .w   (w),
        .sel (sel),
        .y_c (y_c)
    );

    // Pick the channel driven this cycle: re-seed on scan entry or after an empty mask, else hold the pointer.
    always_comb begin
        entry   = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
        fresh   = entry || empty_q;
        if (entry) begin
            cur = SW'(first_at_or_after(MAX_CH'(en_mask), MAX_SW'(ch), N_CH));
        end else if (empty_q) begin
            cur = SW'(first_at_or_after(MAX_CH'(en_mask), '0, N_CH));
        end else begin
            cur = ptr_q;
        end
        cnt_eff = fresh ? '0 : cnt_q;
        adv     = next_enabled(MAX_CH'(en_mask), MAX_SW'(cur), N_CH);
        sel     = (mode == MODE_SCAN) ? cur : s;
    end

    // Next-state and output values for manual, empty-mask and active scan cycles.
    always_comb begin
        f_n     = f;
        ch_n    = ch;
        valid_n = valid;
        fd_n    = 1'b0;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        wrap_n  = wrap_q;
        empty_n = empty_q;
        mode_n  = mode_e'(mode);
        if (mode == MODE_MANUAL) begin
            f_n     = y_c;
            ch_n    = s;
            valid_n = 1'b1;
        end else if (en_mask == '0) begin
            valid_n = 1'b0;
            empty_n = 1'b1;
        end else begin
            f_n     = y_c;
            ch_n    = cur;
            valid_n = 1'b1;
            fd_n    = !fresh && wrap_q;
            empty_n = 1'b0;
            if (cnt_eff == CNT_LAST) begin
                cnt_n  = '0;
                ptr_n  = SW'(adv.idx);
                wrap_n = adv.wrap;
            end else begin
                cnt_n  = cnt_eff + CW'(1);
                ptr_n  = cur;
                wrap_n = 1'b0;
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f          <= '0;
            ch         <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            empty_q    <= 1'b0;
            mode_q     <= MODE_MANUAL;
        end else begin
            f          <= f_n;
            ch         <= ch_n;
            valid      <= valid_n;
            frame_done <= fd_n;
            ptr_q      <= ptr_n;
            cnt_q      <= cnt_n;
            wrap_q     <= wrap_n;
            empty_q    <= empty_n;
            mode_q     <= mode_n;
        end
    end

endmodule

// File: tb/tb_scan_mux_n.sv
// Self-checking bench for scan_mux_n: directed vector tables, corner sequences and random stimulus vs a model.
module tb_scan_mux_n;

    typedef struct {
        int cur;
        int held;
        bit pw;
        bit prev;
        bit emp;
        int f;
        int ch;
        bit v;
        bit fd;
    } model_t;

    typedef struct {
        logic [3:0] s;
        logic       f;
    } man_vec_t;

    typedef struct {
        logic [2:0] ch;
        logic [3:0] f;
        logic       fd;
    } scan_vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 16 channels, 1 bit, dwell 1
    logic [15:0] wa;
    logic [3:0]  sa;
    logic        ma;
    logic [15:0] ea;
    logic        fa;
    logic [3:0]  cha;
    logic        va, fda;

    // DUT B (dwell 1) and DUT C (dwell 3): 8 channels, 4 bits, shared inputs
    logic [31:0] wb;
    logic [2:0]  sb;
    logic        mb;
    logic [7:0]  eb;
    logic [3:0]  fb, fc;
    logic [2:0]  chb, chc;
    logic        vb, fdb, vc, fdc;

    int n_checks = 0;
    int n_fail   = 0;
    model_t mda, mdb, mdc;

    scan_mux_n #(.N_CH(16), .W(1), .DWELL(1)) dut_a (
        .clk(clk), .resetn(resetn), .w(wa), .s(sa), .mode(ma), .en_mask(ea),
        .f(fa), .ch(cha), .valid(va), .frame_done(fda)
    );

    scan_mux_n #(.N_CH(8), .W(4), .DWELL(1)) dut_b (
        .clk(clk), .resetn(resetn), .w(wb), .s(sb), .mode(mb), .en_mask(eb),
        .f(fb), .ch(chb), .valid(vb), .frame_done(fdb)
    );

    scan_mux_n #(.N_CH(8), .W(4), .DWELL(3)) dut_c (
        .clk(clk), .resetn(resetn), .w(wb), .s(sb), .mode(mb), .en_mask(eb),
        .f(fc), .ch(chc), .valid(vc), .frame_done(fdc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic [15:0] f, input logic [7:0] ch, input logic v, input logic fd);
        return {6'b0, f, ch, v, fd};
    endfunction

    function automatic int chan(input logic [63:0] wv, input int k, input int wd);
        logic [63:0] t;
        t = wv >> (k * wd);
        return int'(t & ((64'd1 << wd) - 64'd1));
    endfunction

    // Lowest enabled index at or after start, wrapping; -1 if none.
    function automatic int first_from(input logic [63:0] m, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (m[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    // Behavioural reference: one clock of the scanner, written from the channel-visiting rules.
    function automatic model_t mstep(input model_t m, input int n, input int wd, input int dw,
                                     input logic [63:0] wv, input int s, input bit mode,
                                     input logic [63:0] mask);
        model_t r;
        int nxt;
        r    = m;
        r.fd = 1'b0;
        if (!mode) begin
            r.f    = chan(wv, s, wd);
            r.ch   = s;
            r.v    = 1'b1;
            r.prev = 1'b0;
            return r;
        end
        if (mask == 64'd0) begin
            r.v    = 1'b0;
            r.emp  = 1'b1;
            r.prev = 1'b1;
            return r;
        end
        if (!m.prev || m.emp) begin
            r.cur  = first_from(mask, m.prev ? 0 : m.ch, n);
            r.held = 0;
            r.pw   = 1'b0;
        end
        r.fd   = r.pw;
        r.pw   = 1'b0;
        r.f    = chan(wv, r.cur, wd);
        r.ch   = r.cur;
        r.v    = 1'b1;
        r.prev = 1'b1;
        r.emp  = 1'b0;
        r.held = r.held + 1;
        if (r.held == dw) begin
            nxt    = first_from(mask, r.cur + 1, n);
            r.held = 0;
            r.pw   = (nxt <= r.cur);
            r.cur  = nxt;
        end
        return r;
    endfunction

    task automatic reset_models();
        mda = '{default: 0};
        mdb = '{default: 0};
        mdc = '{default: 0};
    endtask

    // One clock: advance the models with the inputs seen at the edge, then compare all three DUTs.
    task automatic tick();
        @(posedge clk);
        mda = mstep(mda, 16, 1, 1, 64'(wa), int'(sa), ma, 64'(ea));
        mdb = mstep(mdb, 8, 4, 1, 64'(wb), int'(sb), mb, 64'(eb));
        mdc = mstep(mdc, 8, 4, 3, 64'(wb), int'(sb), mb, 64'(eb));
        #1;
        check("model_a", pk(16'(fa), 8'(cha), va, fda), pk(16'(mda.f), 8'(mda.ch), mda.v, mda.fd));
        check("model_b", pk(16'(fb), 8'(chb), vb, fdb), pk(16'(mdb.f), 8'(mdb.ch), mdb.v, mdb.fd));
        check("model_c", pk(16'(fc), 8'(chc), vc, fdc), pk(16'(mdc.f), 8'(mdc.ch), mdc.v, mdc.fd));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, pk(16'(fa), 8'(cha), va, fda), 32'd0);
        check({tag, "_b"}, pk(16'(fb), 8'(chb), vb, fdb), 32'd0);
        check({tag, "_c"}, pk(16'(fc), 8'(chc), vc, fdc), 32'd0);
    endtask

    initial begin
        man_vec_t  man_tab[16];
        scan_vec_t scan_tab[9];
        logic [15:0] wconst;
        int sp_ch[4];

        wconst = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            man_tab[i].s = 4'(i);
            man_tab[i].f = wconst[i];
        end
        for (int i = 0; i < 9; i++) begin
            scan_tab[i].ch = 3'(i % 8);
            scan_tab[i].f  = 4'((i % 8) + 1);
            scan_tab[i].fd = (i == 8);
        end
        sp_ch = '{1, 4, 7, 1};

        wa = 16'hA5C3; sa = '0; ma = 1'b0; ea = 16'hFFFF;
        wb = 32'h8765_4321; sb = '0; mb = 1'b0; eb = 8'hFF;
        reset_models();

        // Reset state while resetn is held low
        #2;
        check_all_zero("reset");
        #5 resetn = 1'b1;

        // Manual sweep on the 16-channel instance
        for (int i = 0; i < 16; i++) begin
            sa = man_tab[i].s;
            tick();
            check("man_f", 32'(fa), 32'(man_tab[i].f));
            check("man_ch", 32'(cha), 32'(man_tab[i].s));
            check("man_valid", 32'(va), 32'd1);
            check("man_fd", 32'(fda), 32'd0);
        end

        // Full scan, dwell 1, all channels enabled
        mb = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("full_ch", 32'(chb), 32'(scan_tab[i].ch));
            check("full_f", 32'(fb), 32'(scan_tab[i].f));
            check("full_fd", 32'(fdb), 32'(scan_tab[i].fd));
        end

        // Sparse mask, dwell 3, entered from channel 0
        mb = 1'b0; sb = 3'd0;
        tick();
        eb = 8'b1001_0010; mb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("sparse_ch", 32'(chc), 32'(sp_ch[i / 3]));
            check("sparse_f", 32'(fc), 32'(sp_ch[i / 3] + 1));
            check("sparse_fd", 32'(fdc), 32'(i == 9));
        end

        // Empty mask freezes outputs, then a single channel resumes
        eb = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("empty", pk(16'(fc), 8'(chc), vc, fdc), pk(16'd2, 8'd1, 1'b0, 1'b0));
        end
        eb = 8'h20;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("single", pk(16'(fc), 8'(chc), vc, fdc), pk(16'd6, 8'd5, 1'b1, (i == 3) || (i == 6)));
        end

        // Mode switching and re-seed from the manual channel
        mb = 1'b0; sb = 3'd4;
        tick();
        check("to_man_ch", 32'(chc), 32'd4);
        eb = 8'hD2; mb = 1'b1;
        tick();
        check("scan_at4", pk(16'(fc), 8'(chc), vc, fdc), pk(16'd5, 8'd4, 1'b1, 1'b0));
        mb = 1'b0; sb = 3'd2;
        tick();
        check("man_ch2", 32'(chc), 32'd2);
        mb = 1'b1;
        tick();
        check("reseed_ch", 32'(chc), 32'd4);

        // Asynchronous reset between clock edges
        #3 resetn = 1'b0;
        #1;
        check_all_zero("async_rst");
        reset_models();
        #2 resetn = 1'b1;
        tick();
        check("post_rst_c", 32'(chc), 32'd1);
        check("post_rst_b", 32'(chb), 32'd1);

        // Random stimulus against the model
        for (int it = 0; it < 600; it++) begin
            wa = 16'($urandom);
            sa = 4'($urandom);
            wb = $urandom;
            sb = 3'($urandom);
            if ($urandom_range(7) == 0) ma = ~ma;
            if ($urandom_range(7) == 0) mb = ~mb;
            case ($urandom_range(5))
                0: ea = 16'h0;
                1: ea = 16'(1) << $urandom_range(15);
                default: ea = 16'($urandom);
            endcase
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(5))
                    0: eb = 8'h0;
                    1: eb = 8'(1) << $urandom_range(7);
                    default: eb = 8'($urandom);
                endcase
            end
            tick();
            if ($urandom_range(149) == 0) begin
                #2 resetn = 1'b0;
                #1;
                check_all_zero("rand_rst");
                reset_models();
                #1 resetn = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_mux_n.md
Name: scan_mux_n

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output, plus an automatic channel scanner.
- Manual mode: the select input picks the channel, as in a plain N-to-1 mux.
- Scan mode: an internal counter steps through enabled channels, holding each for DWELL cycles, and pulses at the end of each frame.
- Sits in front of the display/serialiser paths that currently chain 4-to-1 stages by hand.

Parameters:
- N_CH, 16, number of input channels; power of 2, range 2..64.
- W, 1, data width per channel in bits.
- DWELL, 1, cycles each channel is held in scan mode; range 1..255.
- SW, $clog2(N_CH), select/channel-index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- w  in  N_CH*W  packed channel data; channel k = w[k*W +: W].
- s  in  SW  manual channel select.
- mode  in  1  0 = manual, 1 = scan.
- en_mask  in  N_CH  per-channel enable; scan mode visits only bits set to 1.
- f  out  W  registered selected data.
- ch  out  SW  index of the channel currently driving f.
- valid  out  1  f/ch carry a real selection.
- frame_done  out  1  one-cycle pulse when the scan wraps past the last enabled channel.

Behaviour:
- Reset (resetn=0, asynchronous): f=0, ch=0, valid=0, frame_done=0, dwell counter=0, scan pointer=0. All registers are clocked only by clk.
- Manual mode, mode=0:
  - Each clock: f <= channel s data, ch <= s, valid <= 1. Latency is 1 cycle from s/w to f.
  - en_mask is ignored. frame_done=0.
- Scan mode, mode=1:
  - On entry (mode 0->1 edge as sampled), the pointer loads the lowest enabled index at or after the current ch, and the dwell counter is cleared.
  - Each clock: f <= data of the pointed channel (live w, re-sampled every cycle), ch <= pointer, valid <= 1.
  - The dwell counter increments each cycle. When it reaches DWELL-1, it clears and the pointer advances to the next higher enabled index.
  - If no higher enabled index exists, the pointer wraps to the lowest enabled index and frame_done pulses for 1 cycle, coincident with the first f of the new frame.
  - Exactly one enabled channel: the pointer stays on it, and frame_done pulses every DWELL cycles.
  - en_mask all zero: valid <= 0, f and ch hold their last values, the counter holds, no frame_done. When any bit sets, scanning resumes at the lowest enabled index on the next cycle.
  - en_mask changes mid-dwell: the current channel completes its dwell even if it was just disabled. The next-channel search uses the new mask.
  - DWELL=1: the channel changes every cycle.
- Mode 1->0: the next cycle is pure manual. Scan state is frozen, and the next entry to scan re-seeds from ch as above.
- Next-enabled search is combinational, priority from pointer+1 upward with wrap. No multi-cycle search.
- Reset asserted mid-scan: immediate return to reset values. After release, the first clock in scan mode starts at the lowest enabled channel.

Decomposition:
- Shared package (scan_mux_pkg): MODE_MANUAL=1'b0, MODE_SCAN=1'b1, and a function next_enabled(mask, idx) returning the next set bit index with a wrap flag.
- One sub-module, mux_n_to_1 (parameters N_CH, W): purely combinational indexed select w[sel*W +: W]. Instantiated once, with sel driven from s or the scan pointer.
- The dwell counter, pointer and output registers live in scan_mux_n.

Test Plan:
- Reset and manual mode, N_CH=16, W=1:
  - Reset, then release with mode=0, w=16'hA5C3.
  - Sweep s=0..15 → f equals w[s] one cycle later, ch=s, valid=1, frame_done never asserted.
- Full scan, N_CH=8, W=4, DWELL=1, en_mask=8'hFF, w channel k = k+1:
  - ch sequence 0,1,…,7,0.
  - f sequence 1..8,1.
  - frame_done high only on the cycle ch returns to 0.
- Sparse mask with dwell, DWELL=3, en_mask=8'b1001_0010:
  - Each of ch 1,4,7 is held 3 cycles, then wraps to 1 with frame_done.
  - Full period is 9 cycles.
- Empty and single mask:
  - Drop en_mask to 0 mid-scan → valid=0, f/ch frozen.
  - Set en_mask=8'h20 → ch=5 next cycle, valid=1, frame_done every DWELL cycles.
- Mode switching and async reset:
  - In scan at ch=4, set mode=0, s=2 → ch=2 next cycle.
  - Return to mode=1 with mask bit 2 clear → resumes at the next enabled index ≥2.
  - Pulse resetn low between clock edges → outputs reach 0 without waiting for clk.
